// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - MDUop encodings (4 bits), default latencies, FSM state type and an
//     operation classifier used by ex_mdu.
//   - Optional feature macro MDU_MADD_EN: when defined, MADD/MADDU are
//     recognised as accumulate-multiply ops; otherwise they decode as NOP.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NOP   = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd9;
  localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd10;

  localparam int MDU_MUL_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_MUL  = 3'd1,
    CL_DIV  = 3'd2,
    CL_MTHI = 3'd3,
    CL_MTLO = 3'd4,
    CL_MADD = 3'd5
  } mdu_class_e;

  // Unknown codes (and MADD/MADDU when the feature is off) fall to CL_NONE.
  function automatic mdu_class_e op_class(logic [MDU_OP_W-1:0] op);
    mdu_class_e cls;
    cls = CL_NONE;
    case (op)
      MDU_MULT, MDU_MULTU: cls = CL_MUL;
      MDU_DIV, MDU_DIVU:   cls = CL_DIV;
      MDU_MTHI:            cls = CL_MTHI;
      MDU_MTLO:            cls = CL_MTLO;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU: cls = CL_MADD;
`endif
      default:             cls = CL_NONE;
    endcase
    return cls;
  endfunction

  function automatic logic op_signed(logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// ex_mdu_if: operand/control bundle between the EX stage and the MDU.
//   master (EX stage): drives A, B, MDUop, start; reads busy, HI, LO, result
//   slave  (ex_mdu)  : the reverse
interface ex_mdu_if import mdu_pkg::*;;
  logic [31:0]         A;
  logic [31:0]         B;
  logic [MDU_OP_W-1:0] MDUop;
  logic                start;
  logic                busy;
  logic [31:0]         HI;
  logic [31:0]         LO;
  logic [31:0]         result;

  modport master (output A, B, MDUop, start, input busy, HI, LO, result);
  modport slave  (input A, B, MDUop, start, output busy, HI, LO, result);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational arithmetic core of the MDU.
//   a, b      : operands (rs, rt)
//   is_signed : treat operands as two's complement
//   prod      : 64-bit product
//   quot, rem : quotient (toward zero) and remainder (sign of dividend)
//   div_zero  : b == 0; quot/rem are don't-care in that case
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;

  // Division runs on magnitudes so 0x80000000 / -1 wraps cleanly to
  // 0x80000000 with remainder 0 instead of overflowing a signed divide.
  always_comb begin
    a_neg    = is_signed & a[31];
    b_neg    = is_signed & b[31];
    prod     = {{32{a_neg}}, a} * {{32{b_neg}}, b};
    a_mag    = a_neg ? (~a + 32'd1) : a;
    b_mag    = b_neg ? (~b + 32'd1) : b;
    div_zero = (b == 32'd0);
    b_div    = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_div;
    r_mag    = a_mag % b_div;
    quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit owning the HI/LO registers.
//   clk, rst_n : clock (rising edge), async active-low reset
//   mdu        : ex_mdu_if.slave (A, B, MDUop, start in; busy, HI, LO,
//                result out)
//   Optional feature macro MDU_MADD_EN adds MADD/MADDU accumulate.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | accepts start; MT* write HI/LO directly
// ST_BUSY | counting down; pending result committed when count hits 0
module ex_mdu import mdu_pkg::*; #(
  parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  ex_mdu_if.slave  mdu
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_wr;
`ifdef MDU_MADD_EN
  logic             pend_acc;
`endif

  mdu_class_e  cls;
  logic        is_signed;
  logic        load_pend, commit, mt_hi, mt_lo;
  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic        div_zero;

  assign cls       = op_class(mdu.MDUop);
  assign is_signed = op_signed(mdu.MDUop);

  mdu_arith u_arith (
    .a        (mdu.A),
    .b        (mdu.B),
    .is_signed(is_signed),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_pend = 1'b0;
    commit    = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mdu.start) begin
          case (cls)
            CL_MUL, CL_MADD: begin
              load_pend = 1'b1;
              cnt_d     = CNT_W'(MUL_CYCLES);
              state_d   = ST_BUSY;
            end
            CL_DIV: begin
              load_pend = 1'b1;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = ST_BUSY;
            end
            CL_MTHI: mt_hi = 1'b1;
            CL_MTLO: mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_wr  <= 1'b0;
`ifdef MDU_MADD_EN
      pend_acc <= 1'b0;
`endif
    end else if (load_pend) begin
      if (cls == CL_DIV) begin
        pend_hi <= rem;
        pend_lo <= quot;
        // divide by zero still occupies the unit but leaves HI/LO alone
        pend_wr <= !div_zero;
      end else begin
        pend_hi <= prod[63:32];
        pend_lo <= prod[31:0];
        pend_wr <= 1'b1;
      end
`ifdef MDU_MADD_EN
      pend_acc <= (cls == CL_MADD);
`endif
    end
  end

  // Commit only happens in ST_BUSY and MT* only in ST_IDLE, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (pend_wr) begin
`ifdef MDU_MADD_EN
        // accumulate uses HI/LO as they stand at commit, not at issue
        if (pend_acc) {hi_q, lo_q} <= {hi_q, lo_q} + {pend_hi, pend_lo};
        else          {hi_q, lo_q} <= {pend_hi, pend_lo};
`else
        {hi_q, lo_q} <= {pend_hi, pend_lo};
`endif
      end
    end else begin
      if (mt_hi) hi_q <= mdu.A;
      if (mt_lo) lo_q <= mdu.A;
    end
  end

  always_comb begin
    mdu.result = 32'd0;
    case (mdu.MDUop)
      MDU_MFHI: mdu.result = hi_q;
      MDU_MFLO: mdu.result = lo_q;
      default:  mdu.result = 32'd0;
    endcase
  end

  assign mdu.busy = (state_q == ST_BUSY);
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Multiply/divide unit in the EX stage, beside the integer ALU.
- Consumes the same A/B operand buses the ALU receives and implements the MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO group that the ALU does not cover.
- Owns the architectural HI/LO registers and models multi-cycle latency with a busy flag; the hazard unit uses that flag to stall.
- MFHI/MFLO results go to the EX result mux alongside the ALU output.

Parameters:
- MUL_CYCLES, 5, busy cycles for multiply ops (>=1).
- DIV_CYCLES, 10, busy cycles for divide ops (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  32  operand rs.
- B  input  32  operand rt.
- MDUop  input  4  operation code (package constants).
- start  input  1  issue strobe; qualifies MDUop for one cycle.
- busy  output  1  operation in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- result  output  32  MFHI→HI, MFLO→LO, else 0; combinational on MDUop.

Behaviour:
- Reset (async, rst_n low): HI=0, LO=0, busy=0, counter=0, pending regs=0. Effective immediately, even mid-operation; the in-flight op is discarded.
- Ops: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. Other codes behave as NOP.
- Issue: start=1 and busy=0 at rising edge t.
  - MULT/MULTU/DIV/DIVU: compute the result from A/B sampled at t into pending_hi/pending_lo. Load counter with N (MUL_CYCLES or DIV_CYCLES). busy=1 from t+1.
  - Commit: each edge with busy=1 decrements counter. The edge where counter goes 1→0 writes HI/LO from pending and drops busy. busy is therefore high for exactly N cycles, and HI/LO show the new values in the first cycle busy=0.
  - MTHI/MTLO: HI←A or LO←A at edge t. No busy.
  - MFHI/MFLO: no state change; result is valid combinationally in the same cycle.
- start while busy=1: ignored entirely, including MT*. The pipeline must stall MDU ops while busy; the block does not queue.
- MFHI/MFLO while busy: result returns the old HI/LO. The stall logic prevents this use.
- Arithmetic:
  - MULT: signed 32×32→64; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero (B=0): the op still runs DIV_CYCLES with busy, but HI/LO are left unchanged at commit.
- HI/LO change only at commit, on MT*, or on reset.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds opcodes MADD=9 and MADDU=10. These take MUL_CYCLES; at commit {HI,LO} ← {HI,LO} + A×B (signed or unsigned product), using the HI/LO values current at commit, mod 2^64.
- Undefined: codes 9/10 are NOP and the accumulate adder is absent.

Decomposition:
- Package mdu_pkg: 4-bit MDUop constants, MDU_OP_W=4, default cycle counts.
- Sub-module mdu_arith (combinational): sign-aware 64-bit product, quotient/remainder and div-by-zero flag.
- ex_mdu keeps the counter, pending registers, HI/LO and the issue/commit control.

Test Plan:
- MULT A=0xFFFFFFFD(-3), B=5, start at cycle 0 → busy=1 in cycles 1-5, 0 in cycle 6; HI=0xFFFFFFFF, LO=0xFFFFFFF1 from cycle 6.
- MULTU with the same operands → HI=0x00000004, LO=0xFFFFFFF1.
- DIV A=-7, B=2 → busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 → busy for 10 cycles, HI/LO unchanged.
- MTHI A=0x12345678 then MFHI next cycle → result=0x12345678 with no busy. MTLO issued while a DIV is busy → ignored; LO reflects only the DIV commit.
- Start MULT, pull rst_n low in cycle 3 → busy, HI and LO go to 0 asynchronously; after release, no commit occurs.
- (MDU_MADD_EN) HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 → after 5 busy cycles HI=1, LO=0.
